// File: rtl/lorenz_pkg.sv
// Shared constants and types for the Lorenz-to-DAC feeder: Q6.9 format,
// IEEE-754 double field layout, FSM state encoding and FIFO entry layout.
package lorenz_pkg;

    localparam int FRAC_BITS = 9;
    localparam int FIX_W     = 16;
    localparam logic [FIX_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [FIX_W-1:0] SAT_NEG = 16'h8000;

    localparam int DBL_W      = 64;
    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int DBL_BIAS   = 1023;

    // Exponent thresholds: below MIN_EXP the value is under one LSB, at or
    // above SAT_EXP the magnitude reaches 64 and saturates.
    localparam logic [DBL_EXP_W-1:0] EXP_ALL1   = '1;
    localparam logic [DBL_EXP_W-1:0] MIN_EXP    = DBL_EXP_W'(DBL_BIAS - FRAC_BITS);
    localparam logic [DBL_EXP_W-1:0] SAT_EXP    = DBL_EXP_W'(DBL_BIAS + FIX_W - 1 - FRAC_BITS);
    localparam logic [DBL_EXP_W-1:0] SHIFT_BASE = DBL_EXP_W'(DBL_FRAC_W + DBL_BIAS - FRAC_BITS);

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CONV_Y,
        CONV_Z,
        PUSH
    } state_t;

    typedef struct packed {
        logic [FIX_W-1:0] x;
        logic [FIX_W-1:0] y;
        logic [FIX_W-1:0] z;
    } sample_t;

endpackage

// File: rtl/dbl_to_q69.sv
// Combinational IEEE-754 double to signed Q6.9 conversion, truncating toward
// zero, with saturation at +/-64 and zero for NaN, subnormals and tiny values.
module dbl_to_q69
    import lorenz_pkg::*;
(
    input  logic [DBL_W-1:0] d,
    output logic [FIX_W-1:0] q
);

    logic                  sign;
    logic [DBL_EXP_W-1:0]  exp_f;
    logic [DBL_FRAC_W-1:0] frac_f;
    logic [DBL_FRAC_W:0]   mant;
    logic [DBL_EXP_W-1:0]  shamt;
    logic [FIX_W-2:0]      mag;

    assign {sign, exp_f, frac_f} = d;
    assign mant  = {1'b1, frac_f};
    // Right shift that leaves floor(|value| * 2^FRAC_BITS) in the low bits.
    assign shamt = SHIFT_BASE - exp_f;
    assign mag   = (FIX_W-1)'(mant >> shamt);

    always_comb begin
        q = '0;
        if (exp_f == '0) begin
            q = '0;
        end else if (exp_f == EXP_ALL1) begin
            q = (frac_f != '0) ? '0 : (sign ? SAT_NEG : SAT_POS);
        end else if (exp_f >= SAT_EXP) begin
            q = sign ? SAT_NEG : SAT_POS;
        end else if (exp_f < MIN_EXP) begin
            q = '0;
        end else begin
            q = sign ? -{1'b0, mag} : {1'b0, mag};
        end
    end

endmodule

// File: rtl/lorenz_dac_feeder.sv
// Converts Lorenz (x,y,z) doubles to Q6.9, buffers them and paces them to a DAC.
// Define LORENZ_DAC_OFFSET_BIN_EN to emit offset-binary codes instead of two's complement.
module lorenz_dac_feeder
    import lorenz_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int RATE_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DBL_W-1:0] x_in,
    input  logic [DBL_W-1:0] y_in,
    input  logic [DBL_W-1:0] z_in,
    output logic [FIX_W-1:0] dac_x,
    output logic [FIX_W-1:0] dac_y,
    output logic [FIX_W-1:0] dac_z,
    output logic             dac_strobe,
    output logic [7:0]       underrun_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PACE_W = $clog2(RATE_DIV);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(RATE_DIV - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
`ifdef LORENZ_DAC_OFFSET_BIN_EN
    localparam logic [FIX_W-1:0] OUT_FLIP = SAT_NEG;
`else
    localparam logic [FIX_W-1:0] OUT_FLIP = '0;
`endif

    state_t           state_reg;
    logic             in_ready_reg;
    logic [DBL_W-1:0] x_reg, y_reg, z_reg;
    logic [FIX_W-1:0] qx_reg, qy_reg, qz_reg;
    logic [DBL_W-1:0] conv_in;
    logic [FIX_W-1:0] conv_out;

    sample_t          fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PACE_W-1:0] pace_reg;
    logic [FIX_W-1:0] dac_x_reg, dac_y_reg, dac_z_reg;
    logic             dac_strobe_reg;
    logic [7:0]       underrun_reg;

    logic hs, push, slot, pop, idle_next;

    // in_ready_reg is only ever high in IDLE, so it doubles as the state qualifier.
    assign hs        = in_valid && in_ready_reg;
    assign push      = (state_reg == PUSH);
    assign slot      = (pace_reg == PACE_LAST);
    assign pop       = slot && (count_reg != '0);
    assign idle_next = push || ((state_reg == IDLE) && !hs);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_comb begin
        case (state_reg)
            CONV_Y:  conv_in = y_reg;
            CONV_Z:  conv_in = z_reg;
            default: conv_in = x_reg;
        endcase
    end

    dbl_to_q69 u_conv (
        .d (conv_in),
        .q (conv_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE:    if (hs) state_reg <= CONV_X;
                CONV_X:  state_reg <= CONV_Y;
                CONV_Y:  state_reg <= CONV_Z;
                CONV_Z:  state_reg <= PUSH;
                PUSH:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            in_ready_reg <= idle_next && (count_next != FULL_CNT);
        end
    end

    // Datapath registers and FIFO storage carry no reset; validity lives in the FSM and count.
    always_ff @(posedge clk) begin
        if (hs) begin
            x_reg <= x_in;
            y_reg <= y_in;
            z_reg <= z_in;
        end
        if (state_reg == CONV_X) qx_reg <= conv_out;
        if (state_reg == CONV_Y) qy_reg <= conv_out;
        if (state_reg == CONV_Z) qz_reg <= conv_out;
        if (push) fifo_mem[wr_ptr_reg] <= {qx_reg, qy_reg, qz_reg};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            pace_reg       <= '0;
            dac_x_reg      <= '0;
            dac_y_reg      <= '0;
            dac_z_reg      <= '0;
            dac_strobe_reg <= 1'b0;
            underrun_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg      <= count_next;
            pace_reg       <= slot ? '0 : pace_reg + PACE_W'(1);
            dac_strobe_reg <= pop;
            if (pop) begin
                dac_x_reg <= fifo_mem[rd_ptr_reg].x ^ OUT_FLIP;
                dac_y_reg <= fifo_mem[rd_ptr_reg].y ^ OUT_FLIP;
                dac_z_reg <= fifo_mem[rd_ptr_reg].z ^ OUT_FLIP;
            end else if (slot && (underrun_reg != 8'hFF)) begin
                underrun_reg <= underrun_reg + 8'd1;
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign dac_x        = dac_x_reg;
    assign dac_y        = dac_y_reg;
    assign dac_z        = dac_z_reg;
    assign dac_strobe   = dac_strobe_reg;
    assign underrun_cnt = underrun_reg;

endmodule

// File: tb/tb_lorenz_dac_feeder.sv
// Randomized bench for lorenz_dac_feeder against a cycle-count/queue reference model
// built from the pacing, latency and conversion rules (real arithmetic for conversion).
module tb_lorenz_dac_feeder;

    localparam int DEPTH    = 8;
    localparam int RATE_DIV = 8;
`ifdef LORENZ_DAC_OFFSET_BIN_EN
    localparam logic [15:0] OUT_FLIP = 16'h8000;
`else
    localparam logic [15:0] OUT_FLIP = 16'h0000;
`endif

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        int          avail;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x_in = '0, y_in = '0, z_in = '0;
    logic [15:0] dac_x, dac_y, dac_z;
    logic        dac_strobe;
    logic [7:0]  underrun_cnt;

    always #5 clk = ~clk;

    lorenz_dac_feeder #(.DEPTH(DEPTH), .RATE_DIV(RATE_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .dac_x        (dac_x),
        .dac_y        (dac_y),
        .dac_z        (dac_z),
        .dac_strobe   (dac_strobe),
        .underrun_cnt (underrun_cnt)
    );

    int          n_vec = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    int          edge_n, last_hs, underrun_m, n_updates, dut_strobes;
    logic        exp_ready, exp_strobe;
    logic [15:0] exp_dx, exp_dy, exp_dz;
    logic        pend_valid = 1'b0;
    logic [63:0] pend_x, pend_y, pend_z;
    logic [15:0] pend_ex, pend_ey, pend_ez;
    bit          stream = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_q69(input logic [63:0] d);
        real v;
        int  m;
        if (d[62:52] == 11'h000) return 16'h0000;
        if (d[62:52] == 11'h7FF && d[51:0] != 52'h0) return 16'h0000;
        v = $bitstoreal(d);
        if (v >= 64.0) return 16'h7FFF;
        if (v <= -64.0) return 16'h8000;
        m = $rtoi(v * 512.0);
        return 16'(m);
    endfunction

    function automatic logic [63:0] rand_dbl();
        logic [63:0] d;
        int sel;
        d = {$urandom, $urandom};
        sel = $urandom_range(0, 19);
        if (sel == 0) begin
            d[62:52] = 11'h000;
        end else if (sel == 1) begin
            d[62:52] = 11'h7FF;
            if ($urandom_range(0, 1) == 1) d[51:0] = '0;
        end else if (sel == 2) begin
            d[62:52] = 11'($urandom_range(1029, 1100));
        end else begin
            d[62:52] = 11'($urandom_range(1008, 1028));
        end
        return d;
    endfunction

    task automatic model_reset();
        sb.delete();
        edge_n     = 0;
        last_hs    = -100;
        underrun_m = 0;
        exp_ready  = 1'b0;
        exp_strobe = 1'b0;
        exp_dx     = '0;
        exp_dy     = '0;
        exp_dz     = '0;
    endtask

    task automatic load_random();
        pend_x = rand_dbl();
        pend_y = rand_dbl();
        pend_z = rand_dbl();
        pend_ex = ref_q69(pend_x);
        pend_ey = ref_q69(pend_y);
        pend_ez = ref_q69(pend_z);
        pend_valid = 1'b1;
    endtask

    task automatic check_outputs();
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("dac_strobe", 32'(dac_strobe), 32'(exp_strobe));
        check_eq("underrun_cnt", 32'(underrun_cnt), 32'(underrun_m));
        check_eq("dac_x", 32'(dac_x), 32'(exp_dx));
        check_eq("dac_y", 32'(dac_y), 32'(exp_dy));
        check_eq("dac_z", 32'(dac_z), 32'(exp_dz));
        if (dac_strobe) dut_strobes++;
        if (exp_strobe) begin
            n_updates++;
            $display("dac update %0d: x=%h y=%h z=%h underruns=%0d",
                     n_updates, exp_dx, exp_dy, exp_dz, underrun_m);
        end
    endtask

    // One clock: drive, advance the reference model at the edge, compare on the falling edge.
    task automatic step();
        int   occ;
        exp_t e;
        in_valid = pend_valid;
        x_in = pend_x;
        y_in = pend_y;
        z_in = pend_z;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            exp_strobe = 1'b0;
            if (edge_n % RATE_DIV == RATE_DIV - 1) begin
                if (sb.size() > 0 && sb[0].avail <= edge_n) begin
                    exp_strobe = 1'b1;
                    exp_dx = sb[0].x ^ OUT_FLIP;
                    exp_dy = sb[0].y ^ OUT_FLIP;
                    exp_dz = sb[0].z ^ OUT_FLIP;
                    void'(sb.pop_front());
                end else if (underrun_m < 255) begin
                    underrun_m++;
                end
            end
            if (pend_valid && exp_ready) begin
                e.x = pend_ex;
                e.y = pend_ey;
                e.z = pend_ez;
                e.avail = edge_n + 5;
                sb.push_back(e);
                last_hs = edge_n;
                if (stream) load_random();
                else pend_valid = 1'b0;
            end
            occ = 0;
            foreach (sb[i]) if (sb[i].avail <= edge_n + 1) occ++;
            exp_ready = (edge_n > last_hs + 3) && (occ < DEPTH);
            edge_n++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 60 && pend_valid; i++) step();
        check_eq("accept_timeout", 32'(pend_valid), 32'd0);
        pend_valid = 1'b0;
    endtask

    task automatic send_directed(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z,
                                 input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez);
        pend_x = x;
        pend_y = y;
        pend_z = z;
        pend_ex = ex;
        pend_ey = ey;
        pend_ez = ez;
        pend_valid = 1'b1;
        wait_accept();
    endtask

    task automatic apply_reset(input int n);
        pend_valid = 1'b0;
        stream = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        run(n);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        n_updates = 0;
        dut_strobes = 0;
        run(3);
        reset = 1'b1;

        send_directed(64'h4024000000000000, 64'hC004000000000000, 64'h4005555555555555,
                      16'h1400, 16'hFB00, 16'h0555);
        run(20);
        send_directed(64'h4059000000000000, 64'h7FF8000000000000, 64'hFFF0000000000000,
                      16'h7FFF, 16'h0000, 16'h8000);
        run(20);
        send_directed(64'h4024000000000000, 64'h0000000000000000, 64'h8000000000000000,
                      16'h1400, 16'h0000, 16'h0000);
        run(20);
        send_directed(64'h4050000000000000, 64'hC050000000000000, 64'h3F50000000000000,
                      16'h7FFF, 16'h8000, 16'h0000);
        send_directed(64'h3F60000000000000, 64'h0000000000000001, 64'hBFE8000000000000,
                      16'h0001, 16'h0000, 16'hFE80);
        run(30);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) run($urandom_range(0, 12));
            load_random();
            wait_accept();
        end
        run(80);

        // Continuous in_valid: FIFO fills to DEPTH and in_ready stays low while full.
        stream = 1'b1;
        load_random();
        run(150);
        stream = 1'b0;
        pend_valid = 1'b0;
        run(100);

        // Starvation: 300 empty update slots saturate the underrun counter.
        apply_reset(2);
        dut_strobes = 0;
        run(300 * RATE_DIV + 8);
        check_eq("underrun_saturated", 32'(underrun_cnt), 32'h0000_00FF);
        check_eq("no_strobe_when_starved", 32'(dut_strobes), 32'd0);

        // Reset while the FSM is in CONV_Y.
        apply_reset(2);
        run(5);
        load_random();
        wait_accept();
        step();
        apply_reset(3);
        dut_strobes = 0;
        run(40);
        check_eq("no_strobe_after_reset", 32'(dut_strobes), 32'd0);
        send_directed(64'h4024000000000000, 64'hC004000000000000, 64'h4005555555555555,
                      16'h1400, 16'hFB00, 16'h0555);
        run(30);
        check_eq("post_reset_updates", 32'(dut_strobes), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lorenz_dac_feeder.md
LORENZ_DAC_FEEDER -- requirements
Module: lorenz_dac_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the FIFO depth in samples (power of two, at least 2).
REQ-002 SHALL have parameter RATE_DIV, default 1000, the number of clk cycles between DAC updates (at least 4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the sample handshake from the Lorenz stage.
REQ-006 SHALL have ports x_in, y_in, z_in, input, 64 bits each: IEEE-754 double state values.
REQ-007 SHALL have ports dac_x, dac_y, dac_z, output, 16 bits each: fixed-point DAC codes.
REQ-008 SHALL have port dac_strobe, output, 1 bit: a one-cycle pulse when the dac_* outputs update.
REQ-009 SHALL have port underrun_cnt, output, 8 bits: count of update slots that found the FIFO empty.

Function
REQ-010 SHALL accept a sample when in_valid and in_ready are both high on a clk edge, capturing x_in, y_in and z_in.
REQ-011 SHALL drive in_ready high only when the FSM is in IDLE and the FIFO is not full, so at most one sample is in flight.
REQ-012 SHALL use FSM states IDLE, CONV_X, CONV_Y, CONV_Z and PUSH.
  - IDLE -> CONV_X on handshake.
  - CONV_X -> CONV_Y -> CONV_Z -> PUSH, one cycle each.
  - PUSH -> IDLE.
REQ-013 SHALL convert one value per CONV cycle to signed Q6.9: value*512, truncated toward zero (matches the upstream rmode 1).
REQ-014 SHALL apply these conversion boundary rules:
  - exponent field 0 -> 0x0000.
  - NaN -> 0x0000.
  - +Inf, or |value| >= 64 -> 0x7FFF.
  - -Inf, or value <= -64 -> 0x8000.
  - |value| < 2^-9 -> 0x0000.
  - Negative results are the two's complement of the truncated magnitude.
REQ-015 SHALL write {x,y,z} codes into the FIFO in PUSH; the entry counts as occupied from the next cycle. Latency from handshake to occupancy is 5 cycles.
REQ-016 SHALL never drop a push. Space is guaranteed by REQ-011; a simultaneous pop and push SHALL leave the count unchanged.
REQ-017 SHALL run a free-running pacing counter 0..RATE_DIV-1 that wraps to 0.
REQ-018 SHALL act at pacing count RATE_DIV-1 as follows:
  - FIFO non-empty: pop the oldest entry, register it onto dac_*, and pulse dac_strobe on the next cycle.
  - FIFO empty: hold dac_*, keep dac_strobe low, and increment underrun_cnt, saturating at 0xFF.
REQ-019 SHALL hold dac_* stable between strobes.

Reset
REQ-020 SHALL, while reset is low, force the following:
  - FSM to IDLE and FIFO to empty.
  - Pacing counter, dac_x, dac_y, dac_z, dac_strobe and underrun_cnt to 0.
  - in_ready to 0.
REQ-021 SHALL discard any conversion in progress on reset assertion. in_ready SHALL rise on the first clk edge after reset deasserts.

Configuration
REQ-022 SHALL support the macro LORENZ_DAC_OFFSET_BIN_EN:
  - Defined: dac_* carry offset binary, i.e. the code with its MSB inverted (0 -> 0x8000), for unipolar DACs.
  - Undefined: dac_* carry two's complement.
  - The stored FIFO data SHALL be two's complement in both builds; the inversion is applied at the output register.

Structure
REQ-023 SHALL place the following in shared package lorenz_pkg:
  - Q-format constants: FRAC_BITS=9, FIX_W=16, SAT_POS=0x7FFF, SAT_NEG=0x8000.
  - The double field widths.
  - The FSM state encoding.
REQ-024 SHALL implement the conversion as one combinational sub-module dbl_to_q69, instanced once and time-shared across the three CONV states.

Verification
REQ-025 SHALL cover this scenario: inputs 0x4024000000000000, 0xC004000000000000, 0x4005555555555555 -> dac_x=0x1400, dac_y=0xFB00, dac_z=0x0555 at the first strobe.
REQ-026 SHALL cover this scenario: x=100.0 (0x4059000000000000), y=NaN (0x7FF8000000000000), z=-Inf (0xFFF0000000000000) -> 0x7FFF, 0x0000, 0x8000.
REQ-027 SHALL cover this scenario: in_valid held high with RATE_DIV=8 -> exactly DEPTH entries accepted, in_ready low while full, and the pop/push pair leaves the count at DEPTH.
REQ-028 SHALL cover this scenario: no input for 300 update slots -> underrun_cnt=0xFF, no strobes.
REQ-029 SHALL cover this scenario: reset asserted in CONV_Y -> FIFO empty, no strobe afterwards, and the first post-reset sample converts correctly.
REQ-030 SHALL cover this scenario: with LORENZ_DAC_OFFSET_BIN_EN defined, input 10.0 -> dac_x=0x9400 and input 0.0 -> 0x8000.
